dac_interleave_drv: RTL and testbench
=====================================

Name: dac_interleave_drv

Overview:
- Parametrised driver for interleaved-port dual/multi-channel DACs (AD9767-class IQ mode) running on a single system clock.
- Accepts whole sample frames (one word per channel) over a valid/ready handshake and buffers them two deep.
- Time-multiplexes the words onto one DAC data bus and generates the select, write-strobe and reset pins from counters instead of phase-shifted clocks.
- Adds width justification, two's-complement to offset-binary conversion, underrun handling and an enable.

Parameters:
- NUM_CH, 2, channels per frame (>=2); channel 0 is the IQSEL-high port.
- IN_W, 14, input word width per channel (1..DAC_W+8).
- DAC_W, 14, DAC data bus width.
- WORD_CYCLES, 2, clk cycles each word is held on the bus (>=2, even).
- SIGNED_IN, 1, 1 = inputs are two's complement and converted to offset binary; 0 = straight binary passthrough.
- UNDERRUN_ZERO, 0, 1 = output midscale on underrun; 0 = repeat the last frame.
- RST_HOLD, 4, clk cycles dac_reset stays high after rst deasserts.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous active-low reset.
- en  in  1  streaming enable, sampled at frame boundaries.
- s_data  in  NUM_CH*IN_W  frame; channel k at bits [k*IN_W +: IN_W].
- s_valid  in  1  frame valid.
- s_ready  out  1  buffer can accept a frame.
- dac_data  out  DAC_W  DAC data bus.
- dac_sel  out  1  IQSEL; high while the channel-0 word is on the bus.
- dac_wrt  out  1  IQWRT write strobe.
- dac_reset  out  1  IQRESET, active high.
- dac_ch  out  $clog2(NUM_CH)  channel index of the word currently on the bus.
- underrun_cnt  out  16  saturating count of frame boundaries that found the buffer empty.

Behaviour:
- Reset (rst=0, asynchronous):
  - dac_data = midscale (1<<(DAC_W-1)) if SIGNED_IN, else 0.
  - dac_sel=0, dac_wrt=0, dac_ch=0, s_ready=0, underrun_cnt=0.
  - Buffer emptied, counters cleared, dac_reset=1.
- After rst rises: dac_reset stays 1 for RST_HOLD cycles, then 0. s_ready and the engine stay inactive while dac_reset=1.
- Buffer: 2-entry FIFO of frames.
  - s_ready = !full (registered).
  - A transfer occurs when s_valid&&s_ready. Simultaneous push and pop at full is not possible because s_ready=0; at one entry both happen in the same cycle.
- Engine states:
  - IDLE -> RUN when en=1, dac_reset=0 and the buffer is non-empty; pops a frame into the output register.
  - RUN: cyc_cnt counts 0..WORD_CYCLES-1; ch_cnt advances when cyc_cnt wraps.
  - Frame boundary = cyc_cnt==WORD_CYCLES-1 and ch_cnt==NUM_CH-1. At each boundary:
    - en=0 -> IDLE.
    - Buffer non-empty -> pop the next frame.
    - Buffer empty -> underrun: underrun_cnt+1 (saturating at 0xFFFF); load midscale or keep the last frame per UNDERRUN_ZERO; stay in RUN.
  - en deasserted mid-frame finishes the current frame before returning to IDLE.
- Outputs in RUN (all registered):
  - dac_data, dac_ch and dac_sel (=ch_cnt==0) update on the cycle after cyc_cnt==0 is entered.
  - dac_wrt = 1 for cyc_cnt >= WORD_CYCLES/2, giving half-word setup and hold around its rising edge.
- Outputs in IDLE: dac_wrt=0, dac_sel=0, dac_data=idle code (same as reset value).
- Latency: a frame accepted while in IDLE with en=1 puts channel 0 on the bus 3 cycles after acceptance.
- Width rule, applied before conversion:
  - IN_W<=DAC_W: left-justify, LSBs zero-filled.
  - IN_W>DAC_W: drop the IN_W-DAC_W LSBs (truncation, no rounding).
- SIGNED_IN=1: invert the MSB of the justified word.
- Reset mid-operation: immediate return to reset values; the partial frame and buffered frames are discarded.

Test Plan:
- NUM_CH=2, IN_W=8, DAC_W=14, SIGNED_IN=0; frame {B=0x00, A=0x5A} -> dac_data 0x1680 with dac_sel=1 for 2 cycles, then 0x0000 with dac_sel=0; dac_wrt pattern 0,1,0,1.
- IN_W=14, SIGNED_IN=1; ch0=0x0000, ch1=0x3FFF -> dac_data 0x2000 then 0x1FFF.
- Stream 4 frames back-to-back with s_valid held high -> s_ready never blocks beyond the 2-deep buffer, no gaps, underrun_cnt=0; then starve -> underrun_cnt=1 at the next boundary; dac_data repeats the last frame (UNDERRUN_ZERO=0) or shows 0x2000 (UNDERRUN_ZERO=1).
- Release rst with RST_HOLD=4 -> dac_reset high exactly 4 cycles after rst rises, s_ready=0 until it falls.
- Drop en at ch_cnt=0 of a frame -> the frame finishes on channel 1, then IDLE with dac_wrt=0 and dac_data=0x2000.
- Assert rst mid-frame with 2 frames buffered -> outputs take reset values the same cycle; after reset, no old data appears on dac_data.

Source files
------------

// File: rtl/dac_interleave_drv.sv
// Purpose: interleaved-port DAC driver; buffers whole frames (one word per channel) two deep and
//          time-multiplexes them onto one DAC bus with counter-generated select/strobe/reset pins.
// Latency: a frame accepted in IDLE with en=1 puts channel 0 on the bus 3 cycles after acceptance.
// Backpressure: s_ready (registered) drops while the 2-entry buffer is full or dac_reset is high.
//
// Ports:
//   clk, rst (async active-low)    - system clock / reset
//   en                             - streaming enable, sampled at frame boundaries
//   s_data/s_valid/s_ready         - frame input, channel k at bits [k*IN_W +: IN_W]
//   dac_data/dac_sel/dac_wrt       - DAC bus, IQSEL (channel 0 on bus), IQWRT strobe
//   dac_reset                      - IQRESET, held RST_HOLD cycles after rst releases
//   dac_ch                         - channel index of the word on the bus
//   underrun_cnt                   - saturating count of boundaries that found the buffer empty
module dac_interleave_drv #(
    parameter int NUM_CH        = 2,
    parameter int IN_W          = 14,
    parameter int DAC_W         = 14,
    parameter int WORD_CYCLES   = 2,
    parameter int SIGNED_IN     = 1,
    parameter int UNDERRUN_ZERO = 0,
    parameter int RST_HOLD      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_CH*IN_W-1:0]    s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [DAC_W-1:0]          dac_data,
    output logic                      dac_sel,
    output logic                      dac_wrt,
    output logic                      dac_reset,
    output logic [$clog2(NUM_CH)-1:0] dac_ch,
    output logic [15:0]               underrun_cnt
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int CYC_W  = $clog2(WORD_CYCLES);
    localparam int HOLD_W = $clog2(RST_HOLD + 1) + 1;

    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(WORD_CYCLES - 1);
    localparam logic [CYC_W-1:0]  CYC_HALF  = CYC_W'(WORD_CYCLES / 2);
    localparam logic [DAC_W-1:0]  MIDSCALE  = {1'b1, {(DAC_W-1){1'b0}}};
    localparam logic [DAC_W-1:0]  IDLE_CODE = (SIGNED_IN != 0) ? MIDSCALE : '0;
    localparam logic [HOLD_W-1:0] HOLD_LEN  = HOLD_W'(RST_HOLD);

    typedef logic [NUM_CH-1:0][DAC_W-1:0] frame_t;
    typedef logic [NUM_CH*IN_W-1:0]       raw_t;
    typedef enum logic { ST_IDLE, ST_RUN } state_t;

    // Justify each channel to DAC_W and optionally flip to offset binary. Appending DAC_W zeros and
    // taking the top DAC_W bits covers both widths: left-justify when narrower, truncate LSBs when wider.
    function automatic frame_t conv_frame(input raw_t f);
        frame_t                  r;
        logic [IN_W+DAC_W-1:0]   ext;
        r = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ext  = {f[k*IN_W +: IN_W], {DAC_W{1'b0}}};
            r[k] = ext[IN_W+DAC_W-1 -: DAC_W];
            if (SIGNED_IN != 0) begin
                r[k][DAC_W-1] = ~r[k][DAC_W-1];
            end
        end
        return r;
    endfunction

    // ---------------- frame buffer and reset sequencing ----------------
    raw_t              mem_q [2];
    logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              dac_reset_q, dac_reset_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              push, pop;

    assign push = s_valid && ready_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        dac_reset_d = dac_reset_q;
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        if (dac_reset_q) begin
            hold_d      = hold_q + HOLD_W'(1);
            dac_reset_d = (hold_d < HOLD_LEN);
        end
        // Registered ready looks at the next-cycle occupancy so it never over-accepts.
        ready_d = !dac_reset_d && (cnt_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            ready_q     <= 1'b0;
            dac_reset_q <= 1'b1;
            hold_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            dac_reset_q <= dac_reset_d;
            hold_q      <= hold_d;
        end
    end

    // ---------------- engine ----------------
    state_t            state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    frame_t            frame_q, frame_d;
    logic [15:0]       urun_q, urun_d;
    logic [DAC_W-1:0]  data_q, data_d;
    logic              sel_q, sel_d, wrt_q, wrt_d;
    logic [CH_W-1:0]   dch_q, dch_d;
    logic              boundary;

    assign boundary = (cyc_q == CYC_LAST) && (ch_q == CH_LAST);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        ch_d    = ch_q;
        frame_d = frame_q;
        urun_d  = urun_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && !dac_reset_q && (cnt_q != 2'd0)) begin
                    state_d = ST_RUN;
                    pop     = 1'b1;
                    frame_d = conv_frame(mem_q[rd_ptr_q]);
                    cyc_d   = '0;
                    ch_d    = '0;
                end
            end
            ST_RUN: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    ch_d  = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
                if (boundary) begin
                    if (!en) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q != 2'd0) begin
                        pop     = 1'b1;
                        frame_d = conv_frame(mem_q[rd_ptr_q]);
                    end else begin
                        if (urun_q != 16'hFFFF) urun_d = urun_q + 16'd1;
                        if (UNDERRUN_ZERO != 0) frame_d = {NUM_CH{MIDSCALE}};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs trail the counters by one cycle; data changes only at the start of a word so it
    // is stable for the whole word, and the strobe rises at mid-word for symmetric setup/hold.
    always_comb begin
        data_d = data_q;
        sel_d  = sel_q;
        dch_d  = dch_q;
        wrt_d  = 1'b0;
        if (state_q == ST_RUN) begin
            if (cyc_q == '0) begin
                data_d = frame_q[ch_q];
                sel_d  = (ch_q == '0);
                dch_d  = ch_q;
            end
            wrt_d = (cyc_q >= CYC_HALF);
        end else begin
            data_d = IDLE_CODE;
            sel_d  = 1'b0;
            dch_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            ch_q    <= '0;
            frame_q <= '0;
            urun_q  <= 16'd0;
            data_q  <= IDLE_CODE;
            sel_q   <= 1'b0;
            wrt_q   <= 1'b0;
            dch_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            ch_q    <= ch_d;
            frame_q <= frame_d;
            urun_q  <= urun_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            wrt_q   <= wrt_d;
            dch_q   <= dch_d;
        end
    end

    assign s_ready      = ready_q;
    assign dac_data     = data_q;
    assign dac_sel      = sel_q;
    assign dac_wrt      = wrt_q;
    assign dac_reset    = dac_reset_q;
    assign dac_ch       = dch_q;
    assign underrun_cnt = urun_q;

endmodule

// File: tb/tb_dac_interleave_drv.sv
module tb_dac_interleave_drv;

    logic clk;
    logic rst_n;

    // signed 14-bit instance, repeat-last-frame on underrun
    logic        en_s, valid_s, ready_s, sel_s, wrt_s, dreset_s, ch_s;
    logic [27:0] data_s;
    logic [13:0] dac_s;
    logic [15:0] urun_s;

    // unsigned 8-bit instance, midscale on underrun
    logic        en_u, valid_u, ready_u, sel_u, wrt_u, dreset_u, ch_u;
    logic [15:0] data_u;
    logic [13:0] dac_u;
    logic [15:0] urun_u;

    int err_cnt = 0;
    int chk_cnt = 0;

    dac_interleave_drv #(
        .NUM_CH(2), .IN_W(14), .DAC_W(14), .WORD_CYCLES(2),
        .SIGNED_IN(1), .UNDERRUN_ZERO(0), .RST_HOLD(4)
    ) dut_s (
        .clk(clk), .rst(rst_n), .en(en_s), .s_data(data_s), .s_valid(valid_s), .s_ready(ready_s),
        .dac_data(dac_s), .dac_sel(sel_s), .dac_wrt(wrt_s), .dac_reset(dreset_s), .dac_ch(ch_s),
        .underrun_cnt(urun_s)
    );

    dac_interleave_drv #(
        .NUM_CH(2), .IN_W(8), .DAC_W(14), .WORD_CYCLES(2),
        .SIGNED_IN(0), .UNDERRUN_ZERO(1), .RST_HOLD(4)
    ) dut_u (
        .clk(clk), .rst(rst_n), .en(en_u), .s_data(data_u), .s_valid(valid_u), .s_ready(ready_u),
        .dac_data(dac_u), .dac_sel(sel_u), .dac_wrt(wrt_u), .dac_reset(dreset_u), .dac_ch(ch_u),
        .underrun_cnt(urun_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [27:0] frames [4];
    logic [13:0] exp_words [10];
    logic [13:0] smp_d [26];
    logic        smp_w [26];
    logic [15:0] smp_r [26];
    int          push_edge [4];
    logic [13:0] exp_u_dat [4];
    logic [13:0] exp_s_dat [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic fire;
        int   idx;
        logic saw_old;

        frames[0] = {14'h1000, 14'h0001};
        frames[1] = {14'h3FFE, 14'h2000};
        frames[2] = {14'h1555, 14'h0ABC};
        frames[3] = {14'h3000, 14'h2AAA};
        exp_words = '{14'h2001, 14'h3000, 14'h0000, 14'h1FFE, 14'h2ABC,
                      14'h3555, 14'h0AAA, 14'h1000, 14'h0AAA, 14'h1000};
        exp_u_dat = '{14'h1680, 14'h1680, 14'h0000, 14'h0000};
        exp_s_dat = '{14'h2000, 14'h2000, 14'h1FFF, 14'h1FFF};
        for (int i = 0; i < 4; i++) push_edge[i] = -1;

        rst_n = 1'b0; en_s = 0; en_u = 0; valid_s = 0; valid_u = 0; data_s = '0; data_u = '0;
        repeat (2) @(negedge clk);

        // reset values
        check_eq("rst_data_s", dac_s, 14'h2000);
        check_eq("rst_data_u", dac_u, 14'h0000);
        check_eq("rst_sel", {sel_s, sel_u}, 2'b00);
        check_eq("rst_wrt", {wrt_s, wrt_u}, 2'b00);
        check_eq("rst_ch", {ch_s, ch_u}, 2'b00);
        check_eq("rst_ready", {ready_s, ready_u}, 2'b00);
        check_eq("rst_urun", urun_s, 16'd0);
        check_eq("rst_dreset", {dreset_s, dreset_u}, 2'b11);

        // reset release: dac_reset high for exactly 4 edges, s_ready low until it falls
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check_eq("hold_dreset", dreset_s, (k < 4) ? 1'b1 : 1'b0);
            check_eq("hold_ready", ready_s, (k == 4) ? 1'b1 : 1'b0);
        end

        // single frame on each instance
        en_s = 1; en_u = 1; valid_s = 1; valid_u = 1;
        data_s = {14'h3FFF, 14'h0000};
        data_u = {8'h00, 8'h5A};
        @(negedge clk);            // after accept edge
        valid_s = 0; valid_u = 0;
        @(negedge clk);            // after pop edge
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check_eq("u_data", dac_u, exp_u_dat[j]);
            check_eq("u_sel", sel_u, (j < 2) ? 1'b1 : 1'b0);
            check_eq("u_wrt", wrt_u, j[0]);
            check_eq("u_ch", ch_u, j[1]);
            check_eq("s_data", dac_s, exp_s_dat[j]);
            check_eq("s_wrt", wrt_s, j[0]);
        end

        // starved boundary: both underrun once
        @(negedge clk);
        check_eq("u_urun1", urun_u, 16'd1);
        check_eq("s_urun1", urun_s, 16'd1);
        check_eq("u_zero_ch0", dac_u, 14'h2000);
        en_s = 0; en_u = 0;        // dropped while ch0 of the frame is active
        @(negedge clk);
        @(negedge clk);
        check_eq("s_repeat_ch1", dac_s, 14'h1FFF);
        check_eq("u_zero_ch1", dac_u, 14'h2000);
        check_eq("s_sel_ch1", sel_s, 1'b0);
        @(negedge clk);
        check_eq("s_finish_wrt", wrt_s, 1'b1);
        check_eq("s_finish_ch", ch_s, 1'b1);
        @(negedge clk);
        check_eq("s_idle_data", dac_s, 14'h2000);
        check_eq("s_idle_wrt", wrt_s, 1'b0);
        check_eq("s_idle_sel", sel_s, 1'b0);
        check_eq("u_idle_data", dac_u, 14'h0000);
        check_eq("u_idle_wrt", wrt_u, 1'b0);
        check_eq("s_idle_urun", urun_s, 16'd1);
        repeat (3) @(negedge clk);

        // back-to-back stream of 4 frames, then starvation
        en_s = 1; fire = 0; idx = 0;
        for (int k = 0; k < 26; k++) begin
            if (fire) begin
                push_edge[idx] = k;
                idx++;
            end
            smp_d[k] = dac_s;
            smp_w[k] = wrt_s;
            smp_r[k] = urun_s;
            if (idx < 4) begin
                valid_s = 1;
                data_s  = frames[idx];
            end else begin
                valid_s = 0;
            end
            fire = valid_s && ready_s;
            @(negedge clk);
        end
        check_eq("push0", push_edge[0], 1);
        check_eq("push1", push_edge[1], 2);
        check_eq("push2", push_edge[2], 3);
        check_eq("push3", push_edge[3], 7);
        for (int j = 0; j < 20; j++) begin
            check_eq("stream_data", smp_d[3 + j], exp_words[j / 2]);
            check_eq("stream_wrt", smp_w[3 + j], j[0]);
        end
        check_eq("stream_urun_before", smp_r[17], 16'd1);
        check_eq("stream_urun_after", smp_r[18], 16'd2);

        // fill the buffer while running, then reset mid-frame
        valid_s = 1; data_s = {14'h2222, 14'h1111};
        @(negedge clk);
        data_s = {14'h0333, 14'h0444};
        @(negedge clk);
        valid_s = 0;
        check_eq("full_ready", ready_s, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_data", dac_s, 14'h2000);
        check_eq("mid_rst_sel_wrt", {sel_s, wrt_s}, 2'b00);
        check_eq("mid_rst_ready", ready_s, 1'b0);
        check_eq("mid_rst_dreset", dreset_s, 1'b1);
        check_eq("mid_rst_urun", urun_s, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_old = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (dac_s !== 14'h2000 || wrt_s !== 1'b0 || sel_s !== 1'b0) saw_old = 1'b1;
        end
        check_eq("no_old_data", saw_old, 1'b0);
        check_eq("post_rst_ready", ready_s, 1'b1);
        check_eq("post_rst_urun", urun_s, 16'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
